// File: rtl/appliance_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : appliance_pkg                                          |
// | Description : Shared indices, default weights and scheduler states.  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package appliance_pkg;

  localparam int unsigned NUM_APPLIANCES = 5;

  localparam int unsigned IDX_FRIDGE = 0;
  localparam int unsigned IDX_OVEN   = 1;
  localparam int unsigned IDX_COFFEE = 2;
  localparam int unsigned IDX_WASHER = 3;
  localparam int unsigned IDX_DISH   = 4;

  localparam int unsigned DEF_W_FRIDGE = 20;
  localparam int unsigned DEF_W_OVEN   = 120;
  localparam int unsigned DEF_W_COFFEE = 60;
  localparam int unsigned DEF_W_WASHER = 90;
  localparam int unsigned DEF_W_DISH   = 80;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HOLDOFF = 1'b1
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/appliance_power_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : appliance_power_scheduler_if                           |
// | Description : Request/budget inputs and command outputs of the       |
// |               appliance power scheduler.                             |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface appliance_power_scheduler_if #(
  parameter int unsigned LOAD_W = 8
);
  import appliance_pkg::*;

  logic [NUM_APPLIANCES-1:0] req;
  logic [LOAD_W+2:0]         load_budget;
  logic                      fridge_cmd;
  logic                      oven_cmd;
  logic                      coffee_maker_cmd;
  logic                      washer_cmd;
  logic                      dishwasher_cmd;
  logic [LOAD_W+2:0]         load_now;
  logic [NUM_APPLIANCES-1:0] pending;
  logic                      busy;

  modport master (
    output req, load_budget,
    input  fridge_cmd, oven_cmd, coffee_maker_cmd, washer_cmd, dishwasher_cmd,
    input  load_now, pending, busy
  );

  modport slave (
    input  req, load_budget,
    output fridge_cmd, oven_cmd, coffee_maker_cmd, washer_cmd, dishwasher_cmd,
    output load_now, pending, busy
  );

endinterface
`default_nettype wire

// File: rtl/appliance_min_on_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : appliance_min_on_timer                                 |
// | Description : Holds one appliance command on for MIN_ON_CYCLES after |
// |               its grant edge.                                        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module appliance_min_on_timer #(
  parameter int unsigned MIN_ON_CYCLES = 64
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_load,
  output logic      o_hold
);

  localparam int unsigned c_cnt_w = (MIN_ON_CYCLES > 1) ? $clog2(MIN_ON_CYCLES) : 1;

  logic [c_cnt_w-1:0] r_cnt;

  // Loaded with N-1 so the command may clear exactly N edges after the grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= c_cnt_w'(MIN_ON_CYCLES - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_hold = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/appliance_power_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : appliance_power_scheduler                              |
// | Description : Budget-limited, staggered turn-on of five appliances.  |
// |               Optional min-on timers under APPLIANCE_MIN_ON_EN.      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module appliance_power_scheduler
  import appliance_pkg::*;
#(
  parameter int unsigned LOAD_W         = 8,
  parameter int unsigned W_FRIDGE       = DEF_W_FRIDGE,
  parameter int unsigned W_OVEN         = DEF_W_OVEN,
  parameter int unsigned W_COFFEE       = DEF_W_COFFEE,
  parameter int unsigned W_WASHER       = DEF_W_WASHER,
  parameter int unsigned W_DISH         = DEF_W_DISH,
  parameter int          STAGGER_CYCLES = 16,
  parameter int unsigned MIN_ON_CYCLES  = 64
) (
  input wire logic                  clk,
  input wire logic                  rst,
  appliance_power_scheduler_if.slave bus
);

  localparam int unsigned c_sum_w = LOAD_W + 3;
  localparam int unsigned c_cnt_w = (STAGGER_CYCLES > 2) ? $clog2(STAGGER_CYCLES - 1) : 1;

  localparam logic [NUM_APPLIANCES-1:0][c_sum_w-1:0] c_weight = {
    c_sum_w'(LOAD_W'(W_DISH)),
    c_sum_w'(LOAD_W'(W_WASHER)),
    c_sum_w'(LOAD_W'(W_COFFEE)),
    c_sum_w'(LOAD_W'(W_OVEN)),
    c_sum_w'(LOAD_W'(W_FRIDGE))
  };

  sched_state_t              r_state;
  sched_state_t              w_state_nxt;
  logic [c_cnt_w-1:0]        r_cnt;
  logic [c_cnt_w-1:0]        w_cnt_nxt;
  logic [NUM_APPLIANCES-1:0] r_cmd;
  logic [NUM_APPLIANCES-1:0] w_cmd_nxt;
  logic [c_sum_w-1:0]        r_load_now;
  logic [c_sum_w-1:0]        w_load_nxt;
  logic [NUM_APPLIANCES-1:0] w_fits;
  logic [NUM_APPLIANCES-1:0] w_elig;
  logic [NUM_APPLIANCES-1:0] w_pick;
  logic [NUM_APPLIANCES-1:0] w_grant;
  logic [NUM_APPLIANCES-1:0] w_drop;
  logic [NUM_APPLIANCES-1:0] w_hold;

`ifdef APPLIANCE_MIN_ON_EN
  for (genvar gi = 0; gi < NUM_APPLIANCES; gi++) begin : g_min_on
    appliance_min_on_timer #(
      .MIN_ON_CYCLES (MIN_ON_CYCLES)
    ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_grant[gi]),
      .o_hold (w_hold[gi])
    );
  end
`else
  assign w_hold = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cmd      <= '0;
      r_load_now <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cmd      <= w_cmd_nxt;
      r_load_now <= w_load_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pick      = '0;

    // Budget check uses the registered load; same-cycle turn-offs free nothing yet.
    for (int i = 0; i < NUM_APPLIANCES; i++) begin
      w_fits[i] = (r_load_now + c_weight[i]) <= bus.load_budget;
    end
    w_elig = bus.req & ~r_cmd & w_fits;

    // Scan from lowest priority upward so the highest-priority hit wins.
    for (int i = NUM_APPLIANCES - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_pick    = '0;
        w_pick[i] = 1'b1;
      end
    end

    w_grant = (r_state == IDLE) ? w_pick : '0;
    w_drop  = r_cmd & ~bus.req & ~w_hold;

    case (r_state)
      IDLE: begin
        if ((|w_grant) && (STAGGER_CYCLES > 1)) begin
          w_state_nxt = HOLDOFF;
          w_cnt_nxt   = c_cnt_w'(STAGGER_CYCLES - 2);
        end
      end
      HOLDOFF: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_cmd_nxt  = (r_cmd & ~w_drop) | w_grant;
    w_load_nxt = r_load_now;
    for (int i = 0; i < NUM_APPLIANCES; i++) begin
      if (w_grant[i]) w_load_nxt = w_load_nxt + c_weight[i];
      if (w_drop[i])  w_load_nxt = w_load_nxt - c_weight[i];
    end
  end

  assign bus.fridge_cmd       = r_cmd[IDX_FRIDGE];
  assign bus.oven_cmd         = r_cmd[IDX_OVEN];
  assign bus.coffee_maker_cmd = r_cmd[IDX_COFFEE];
  assign bus.washer_cmd       = r_cmd[IDX_WASHER];
  assign bus.dishwasher_cmd   = r_cmd[IDX_DISH];
  assign bus.load_now         = r_load_now;
  assign bus.pending          = bus.req & ~r_cmd;
  assign bus.busy             = (r_state == HOLDOFF);

endmodule
`default_nettype wire
